// File: rtl/ifu_prefetch_pkg.sv
// Shared types and defaults for the instruction prefetch stage.
package ifu_prefetch_pkg;

  localparam int          ADDR_W       = 32;
  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  // One buffered fetch: the PC it was read from and the returned word.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Small {pc, instr} FIFO; head is read straight from registered storage.
module ifu_prefetch_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state: flush drops everything and ignores a same-cycle push/pop.
  always_comb begin
    do_pop   = pop & !empty;
    do_push  = push & (!full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage and pointers; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: owns the fetch PC, reads the 1-cycle ROM and
// queues {pc, instr} for decode. Redirect flushes queued and in-flight work.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  output logic                im_req,
  output logic [ADDR_W-1:0]   im_addr,
  input  logic [INSTR_W-1:0]  im_rdata,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                out_valid,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [INSTR_W-1:0]  out_instr,
  input  logic                out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_of_req_q, pc_of_req_d;
  logic              inflight_q, inflight_d;
  logic              epoch_q, epoch_d;
  logic              req_epoch_q, req_epoch_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [UW-1:0]     used;
  logic              push, pop;
  fetch_entry_t      push_data, head;

  // Credit: queued plus in-flight must leave room; a pop this cycle earns no credit.
  always_comb begin
    used   = {1'b0, fifo_count} + UW'(inflight_q);
    im_req = !reset && !redirect_valid && !fifo_full && (used < UW'(DEPTH));
  end

  assign im_addr   = fetch_pc_q;
  assign push      = inflight_q && (req_epoch_q == epoch_q);
  assign push_data = '{pc: pc_of_req_q, instr: im_rdata};
  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  // Fetch-PC / request tracking; the epoch tags each request so a response
  // issued before a redirect can never land in the new stream.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pc_of_req_d = pc_of_req_q;
    req_epoch_d = req_epoch_q;
    inflight_d  = im_req;
    epoch_d     = epoch_q ^ redirect_valid;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
    end else if (im_req) begin
      fetch_pc_d  = fetch_pc_q + 32'd4;
      pc_of_req_d = fetch_pc_q;
      req_epoch_d = epoch_q;
    end
  end

  // Control registers; reset beats redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      pc_of_req_q <= '0;
      inflight_q  <= 1'b0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pc_of_req_q <= pc_of_req_d;
      inflight_q  <= inflight_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
    end
  end

  ifu_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
